// File: rtl/serial_slave_port.sv
// Bit-serial slave endpoint. Shifts in the address, burst length and write
// data LSB first, accesses a local word memory, and shifts read data back
// under a valid/ready handshake. It can optionally raise a split request
// while read data is being prepared. All outputs are registered and are
// derived from the next state, so they always describe the current state.
module serial_slave_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_WIDTH   = 4,
  parameter int SPLIT_LATENCY = 0
) (
  input  logic S_CLK,
  input  logic S_RST,
  input  logic S_M_VALID,
  input  logic S_M_READY,
  input  logic S_RX_ADDR,
  input  logic S_RX_DATA,
  input  logic S_RX_BURST,
  input  logic S_WRITE_EN,
  input  logic S_READ_EN,
  output logic S_DATA_TX,
  output logic S_SLAVE_READY,
  output logic S_SLAVE_VALID,
  output logic S_SPLIT_EN,
  output logic S_TX_DONE
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int SCW   = (SPLIT_LATENCY > 1) ? $clog2(SPLIT_LATENCY + 1) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RFETCH = 3'd4,
    ST_SPLIT  = 3'd5,
    ST_RDATA  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [BURST_WIDTH-1:0]  beat_q, beat_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]          split_cnt_q, split_cnt_d;
  logic                    split_done_q, split_done_d;
  logic                    is_write_q, is_write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   txsh_q, txsh_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    tx_q, tx_d;
  logic                    split_q, split_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    hs_s;
  logic                    last_beat_s;
  logic [BURST_WIDTH-1:0]  beats_m1_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    bit_cnt_d    = bit_cnt_q;
    split_cnt_d  = split_cnt_q;
    split_done_d = split_done_q;
    is_write_d   = is_write_q;
    wdata_d      = wdata_q;
    txsh_d       = txsh_q;

    hs_s = S_M_VALID & ready_q;
    // A burst value of zero still means one beat
    if (burst_q == '0) begin
      beats_m1_s = '0;
    end else begin
      beats_m1_s = burst_q - BURST_WIDTH'(1);
    end
    last_beat_s = (beat_q == beats_m1_s);

    case (state_q)
      ST_IDLE: begin
        if (hs_s && (S_WRITE_EN ^ S_READ_EN)) begin
          is_write_d   = S_WRITE_EN;
          addr_d       = {S_RX_ADDR, addr_q[ADDR_WIDTH-1:1]};
          burst_d      = {S_RX_BURST, burst_q[BURST_WIDTH-1:1]};
          bit_cnt_d    = CW'(1);
          beat_d       = '0;
          split_done_d = 1'b0;
          state_d      = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hs_s) begin
          addr_d = {S_RX_ADDR, addr_q[ADDR_WIDTH-1:1]};
          // Burst bits ride along with the first BURST_WIDTH address bits
          if (bit_cnt_q < CW'(BURST_WIDTH)) begin
            burst_d = {S_RX_BURST, burst_q[BURST_WIDTH-1:1]};
          end else begin
            burst_d = burst_q;
          end
          if (bit_cnt_q == CW'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = is_write_q ? ST_WDATA : ST_RFETCH;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (hs_s) begin
          wdata_d = {S_RX_DATA, wdata_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_beat_s) begin
          state_d = ST_DONE;
        end else begin
          beat_d  = beat_q + BURST_WIDTH'(1);
          state_d = ST_WDATA;
        end
      end
      ST_RFETCH: begin
        txsh_d    = mem_q[addr_q];
        bit_cnt_d = '0;
        // Split only once, ahead of the first beat
        if ((SPLIT_LATENCY > 0) && !split_done_q) begin
          split_cnt_d = '0;
          state_d     = ST_SPLIT;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_SPLIT: begin
        if (split_cnt_q == SCW'(SPLIT_LATENCY - 1)) begin
          split_done_d = 1'b1;
          state_d      = ST_RDATA;
        end else begin
          split_cnt_d = split_cnt_q + SCW'(1);
        end
      end
      ST_RDATA: begin
        if (S_M_READY) begin
          txsh_d = txsh_q >> 1;
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            addr_d    = addr_q + ADDR_WIDTH'(1);
            if (last_beat_s) begin
              state_d = ST_DONE;
            end else begin
              beat_d  = beat_q + BURST_WIDTH'(1);
              state_d = ST_RFETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
    valid_d = (state_d == ST_RDATA);
    tx_d    = (state_d == ST_RDATA) & txsh_d[0];
    split_d = (state_d == ST_SPLIT);
    done_d  = (state_d == ST_DONE);
  end

  // State, counters and output registers; reset aborts any transaction
  always_ff @(posedge S_CLK or negedge S_RST) begin
    if (!S_RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      bit_cnt_q    <= '0;
      split_cnt_q  <= '0;
      split_done_q <= 1'b0;
      is_write_q   <= 1'b0;
      wdata_q      <= '0;
      txsh_q       <= '0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      tx_q         <= 1'b0;
      split_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      bit_cnt_q    <= bit_cnt_d;
      split_cnt_q  <= split_cnt_d;
      split_done_q <= split_done_d;
      is_write_q   <= is_write_d;
      wdata_q      <= wdata_d;
      txsh_q       <= txsh_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      tx_q         <= tx_d;
      split_q      <= split_d;
      done_q       <= done_d;
    end
  end

  // Word memory: not cleared by reset, written only from the WRITE state
  always_ff @(posedge S_CLK) begin
    if (state_q == ST_WRITE) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign S_DATA_TX     = tx_q;
  assign S_SLAVE_READY = ready_q;
  assign S_SLAVE_VALID = valid_q;
  assign S_SPLIT_EN    = split_q;
  assign S_TX_DONE     = done_q;

endmodule
